// File: rtl/hpdmc_pkg.sv
// hpdmc_pkg: shared state encoding, default DDR data-phase timing and counter sizing
// for the HPDMC data-path control blocks.
package hpdmc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    WTR,
    RTW
  } state_e;

  localparam int unsigned DEF_CL   = 2;
  localparam int unsigned DEF_BL   = 4;
  localparam int unsigned DEF_TWTR = 2;
  localparam int unsigned DEF_TRTW = 2;
  localparam int unsigned DEF_TWR  = 2;

  // Bits needed to hold the largest of the supplied timing values.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d,
                                            input int unsigned e);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  localparam int unsigned CNT_W = cnt_width(DEF_CL, DEF_BL, DEF_TWTR, DEF_TRTW, DEF_TWR);

endpackage

// File: rtl/hpdmc_datactl_if.sv
// hpdmc_datactl_if: scheduler/IO-facing command and data-window signals of hpdmc_datactl.
interface hpdmc_datactl_if;
  logic read;
  logic write;
  logic read_safe;
  logic write_safe;
  logic precharge_safe;
  logic op_read;
  logic op_write;
  logic burst_done;
  logic protocol_err;

  modport master (
    output read, write,
    input  read_safe, write_safe, precharge_safe,
    input  op_read, op_write, burst_done, protocol_err
  );

  modport slave (
    input  read, write,
    output read_safe, write_safe, precharge_safe,
    output op_read, op_write, burst_done, protocol_err
  );
endinterface

// File: rtl/hpdmc_dly_cnt.sv
// hpdmc_dly_cnt: loadable down-counter that saturates at zero, with a zero flag.
module hpdmc_dly_cnt #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= value;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hpdmc_datactl.sv
// hpdmc_datactl: turns accepted read/write column commands into op_read/op_write windows
// and gates the scheduler. Define HPDMC_DATACTL_CHECK_EN to include the protocol checker.
module hpdmc_datactl
  import hpdmc_pkg::*;
#(
  parameter int unsigned CL   = DEF_CL,
  parameter int unsigned BL   = DEF_BL,
  parameter int unsigned TWTR = DEF_TWTR,
  parameter int unsigned TRTW = DEF_TRTW,
  parameter int unsigned TWR  = DEF_TWR
) (
  input  logic           clk,
  input  logic           rst,
  hpdmc_datactl_if.slave bus
);

  localparam int unsigned   W   = cnt_width(CL, BL, TWTR, TRTW, TWR);
  localparam int unsigned   DLY = CL - 1;
  localparam logic [W-1:0]  ONE = W'(1);

  state_e         state, state_n;
  logic           read_safe, write_safe, precharge_safe;
  logic           rd_acc, wr_acc, rd_launch, wr_end, rd_end;
  logic [DLY-1:0] rd_pipe;
  logic [W-1:0]   wr_cnt, rd_cnt, ta_cnt, rec_cnt, iss_cnt, ta_value;
  logic           wr_zero, rd_zero, ta_zero, rec_zero, iss_zero;
  logic           unused_cnt;

  assign rd_acc    = bus.read & read_safe;
  assign wr_acc    = bus.write & write_safe & ~bus.read;
  assign rd_launch = rd_pipe[DLY-1];

  // A window only ends if nothing chains onto it; for reads a burst still in the
  // delay line also keeps the machine in RD.
  assign wr_end   = (wr_cnt == ONE) & ~wr_acc;
  assign rd_end   = (rd_cnt == ONE) & ~rd_acc & (rd_pipe == '0);
  assign ta_value = wr_end ? W'(TWTR) : W'(TRTW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_pipe <= '0;
    else     rd_pipe <= DLY'({rd_pipe, rd_acc});
  end

  hpdmc_dly_cnt #(.W(W)) u_wr_win (
    .clk(clk), .rst(rst), .load(wr_acc), .value(W'(BL)), .cnt(wr_cnt), .zero(wr_zero)
  );

  hpdmc_dly_cnt #(.W(W)) u_rd_win (
    .clk(clk), .rst(rst), .load(rd_launch), .value(W'(BL)), .cnt(rd_cnt), .zero(rd_zero)
  );

  // Tracks the newest read from issue, so the burst still in the delay line has its own count.
  hpdmc_dly_cnt #(.W(W)) u_rd_iss (
    .clk(clk), .rst(rst), .load(rd_acc), .value(W'(BL - 1)), .cnt(iss_cnt), .zero(iss_zero)
  );

  hpdmc_dly_cnt #(.W(W)) u_turn (
    .clk(clk), .rst(rst), .load(wr_end | rd_end), .value(ta_value), .cnt(ta_cnt), .zero(ta_zero)
  );

  hpdmc_dly_cnt #(.W(W)) u_rec (
    .clk(clk), .rst(rst), .load(wr_end), .value(W'(TWR)), .cnt(rec_cnt), .zero(rec_zero)
  );

  assign unused_cnt = ^{rec_cnt, iss_cnt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (rd_acc)      state_n = RD;
        else if (wr_acc) state_n = WR;
      end
      WR:  if (wr_end) state_n = (TWTR == 0) ? IDLE : WTR;
      RD:  if (rd_end) state_n = (TRTW == 0) ? IDLE : RTW;
      WTR: begin
        if (wr_acc)                          state_n = WR;
        else if (ta_zero || ta_cnt == ONE)   state_n = IDLE;
      end
      RTW: begin
        if (rd_acc)                          state_n = RD;
        else if (ta_zero || ta_cnt == ONE)   state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    read_safe      = 1'b1;
    write_safe     = 1'b1;
    precharge_safe = rec_zero;
    unique case (state)
      WR: begin
        read_safe      = 1'b0;
        write_safe     = wr_zero | (wr_cnt == ONE);
        precharge_safe = 1'b0;
      end
      RD: begin
        read_safe      = iss_zero;
        write_safe     = 1'b0;
        precharge_safe = rec_zero & iss_zero;
      end
      WTR: begin
        read_safe      = 1'b0;
        precharge_safe = 1'b0;
      end
      RTW:     write_safe = 1'b0;
      default: ;
    endcase
  end

  assign bus.read_safe      = read_safe;
  assign bus.write_safe     = write_safe;
  assign bus.precharge_safe = precharge_safe;
  assign bus.op_write       = ~wr_zero;
  assign bus.op_read        = ~rd_zero;
  assign bus.burst_done     = (wr_cnt == ONE) | (rd_cnt == ONE);

`ifdef HPDMC_DATACTL_CHECK_EN
  logic err_q, viol_both, viol_rd, viol_wr;

  assign viol_both = bus.read & bus.write;
  assign viol_rd   = bus.read & ~read_safe;
  assign viol_wr   = bus.write & ~bus.read & ~write_safe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                err_q <= 1'b0;
    else if (viol_both | viol_rd | viol_wr) err_q <= 1'b1;
  end

  assign bus.protocol_err = err_q;

`ifndef SYNTHESIS
  longint unsigned cyc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc <= '0;
    else begin
      cyc <= cyc + 1;
      if (viol_both) $display("hpdmc_datactl: protocol violation at cycle %0d: read and write together", cyc);
      if (viol_rd)   $display("hpdmc_datactl: protocol violation at cycle %0d: read while read_safe low", cyc);
      if (viol_wr)   $display("hpdmc_datactl: protocol violation at cycle %0d: write while write_safe low", cyc);
    end
  end
`endif
`else
  assign bus.protocol_err = 1'b0;
`endif

endmodule
